// File: rtl/if_id_queue.sv
// Elastic IF/ID boundary: DEPTH-entry queue between fetch and decode with
// registered head outputs, pre-sliced decode fields, flush and NOP bubbles.
module if_id_queue #(
    parameter int unsigned INSTR_W = 20,
    parameter int unsigned PC_W    = 8,
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned REG_W   = 4,
    parameter int unsigned OPA_LSB = 8,
    parameter int unsigned OPB_LSB = 4,
    parameter int unsigned OPC_LSB = 16,
    parameter int unsigned OPC_W   = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [INSTR_W-1:0]           in_instr,
    input  logic [PC_W-1:0]              in_pc,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [INSTR_W-1:0]           out_instr,
    output logic [PC_W-1:0]              out_pc,
    output logic [OPC_W-1:0]             out_opcode,
    output logic [REG_W-1:0]             out_opA,
    output logic [REG_W-1:0]             out_opB,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [INSTR_W-1:0] r_mem_instr [DEPTH];
    logic [PC_W-1:0]    r_mem_pc    [DEPTH];

    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [INSTR_W-1:0] r_out_instr;
    logic [PC_W-1:0]    r_out_pc;
    logic [OPC_W-1:0]   r_out_opcode;
    logic [REG_W-1:0]   r_out_opA;
    logic [REG_W-1:0]   r_out_opB;

    logic               w_push;
    logic               w_pop;
    logic [CNT_W-1:0]   w_count_nxt;
    logic [CNT_W-1:0]   w_remain;
    logic [PTR_W-1:0]   w_wptr_nxt;
    logic [PTR_W-1:0]   w_rptr_nxt;
    logic [INSTR_W-1:0] w_head_instr;
    logic [PC_W-1:0]    w_head_pc;

    // Next queue state and the entry that will sit at the head after this edge.
    always_comb begin
        w_push       = in_valid && r_in_ready;
        w_pop        = r_out_valid && out_ready;
        w_count_nxt  = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        w_remain     = r_count - CNT_W'(w_pop);
        w_wptr_nxt   = w_push ? r_wptr + PTR_W'(1) : r_wptr;
        w_rptr_nxt   = w_pop  ? r_rptr + PTR_W'(1) : r_rptr;
        w_head_instr = '0;
        w_head_pc    = '0;
        if (w_count_nxt != '0) begin
            // Nothing left behind the popped head: the incoming entry bypasses storage.
            if (w_remain == '0) begin
                w_head_instr = in_instr;
                w_head_pc    = in_pc;
            end else begin
                w_head_instr = r_mem_instr[w_rptr_nxt];
                w_head_pc    = r_mem_pc[w_rptr_nxt];
            end
        end
    end

    // Entry storage; stale writes after flush/reset are harmless since pointers clear.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem_instr[r_wptr] <= in_instr;
            r_mem_pc[r_wptr]    <= in_pc;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_in_ready   <= 1'b1;
            r_out_valid  <= 1'b0;
            r_out_instr  <= '0;
            r_out_pc     <= '0;
            r_out_opcode <= '0;
            r_out_opA    <= '0;
            r_out_opB    <= '0;
        end else begin
            r_wptr       <= w_wptr_nxt;
            r_rptr       <= w_rptr_nxt;
            r_count      <= w_count_nxt;
            r_in_ready   <= (w_count_nxt < CNT_W'(DEPTH));
            r_out_valid  <= (w_count_nxt != '0);
            r_out_instr  <= w_head_instr;
            r_out_pc     <= w_head_pc;
            r_out_opcode <= w_head_instr[OPC_LSB +: OPC_W];
            r_out_opA    <= w_head_instr[OPA_LSB +: REG_W];
            r_out_opB    <= w_head_instr[OPB_LSB +: REG_W];
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign out_instr  = r_out_instr;
    assign out_pc     = r_out_pc;
    assign out_opcode = r_out_opcode;
    assign out_opA    = r_out_opA;
    assign out_opB    = r_out_opB;
    assign count      = r_count;

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Parametrised IF/ID pipeline boundary. Replaces the single-stage IF/ID latch with a DEPTH-entry elastic queue between fetch and decode.
- Uses a valid/ready handshake on both sides, plus flush for branch mispredicts and bubble (NOP) insertion when empty.
- Each entry carries the instruction word and its PC.
- Outputs the head entry together with pre-extracted opcode, opA and opB fields for the decode stage.

Parameters:
INSTR_W, 20, instruction word width
PC_W, 8, program counter width
DEPTH, 2, queue entries; power of two, >= 2
REG_W, 4, register-specifier field width
OPA_LSB, 8, LSB of opA field in the instruction
OPB_LSB, 4, LSB of opB field in the instruction
OPC_LSB, 16, LSB of opcode field
OPC_W, 4, opcode field width

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
flush  in  1  synchronous discard of all queued entries
in_valid  in  1  fetch presents an entry
in_ready  out  1  queue can accept an entry this cycle
in_instr  in  INSTR_W  fetched instruction
in_pc  in  PC_W  PC of the fetched instruction
out_valid  out  1  head entry valid for decode
out_ready  in  1  decode consumes the head this cycle
out_instr  out  INSTR_W  head instruction (instructionPropagation successor)
out_pc  out  PC_W  head PC
out_opcode  out  OPC_W  in_instr[OPC_LSB +: OPC_W] of the head
out_opA  out  REG_W  head instr[OPA_LSB +: REG_W]
out_opB  out  REG_W  head instr[OPB_LSB +: REG_W]
count  out  clog2(DEPTH+1)  entries currently held

Behaviour:
- Clock and reset: reset is synchronous and active-high; clock is `clock`.
- Reset values: count=0, out_valid=0, and out_instr, out_pc, out_opcode, out_opA and out_opB all zero. Read and write pointers are 0. in_ready=1 on the first cycle after reset.
- Priority: reset > flush > push/pop.
- Push: occurs when in_valid && in_ready at a clock edge.
- Pop: occurs when out_valid && out_ready at a clock edge.
- in_ready: equals (count < DEPTH). It is registered state only, with no combinational path from out_ready.
- Latency: an entry pushed into an empty queue at edge N appears on out_* with out_valid=1 after edge N. This is one-cycle latency, identical to the old latch.
- Output registers: all out_* are registers reflecting the current head.
  - After a pop, the next entry (if any) is presented after the same edge.
  - Back-to-back push/pop at count=1 sustains one instruction per cycle.
- Simultaneous push and pop: count is unchanged and both pointers advance.
  - When count=1, the pushed entry becomes the new head after the edge.
  - When count=DEPTH, no push is possible because in_ready=0.
- Stall: while out_valid=1 and out_ready=0, all out_* hold stable, and pushes continue until full.
- Empty / bubble: when count=0, out_valid=0 and all out_* data fields are driven to 0 (NOP). Decode therefore sees a clean bubble, with no stale opA/opB.
- Full: when count=DEPTH, in_ready=0 and in_valid is ignored; the fetch stage must hold its entry.
- Wrap-around: pointers are clog2(DEPTH) bits and wrap naturally modulo DEPTH. Count disambiguates full from empty.
- Flush: takes effect at the edge where flush=1.
  - count←0, pointers←0, out_valid←0, and out_* data←0.
  - A push or pop requested in the same cycle is discarded.
  - in_ready=1 on the following cycle.
- Reset mid-operation: all queued entries are lost and the block is in the same state as after power-up reset.
- Field extraction: this is pure bit-slicing of the stored instruction, performed when the head register loads. No sign extension.
- Illegal handshakes: out_ready while out_valid=0 is ignored, and in_valid while full is ignored. Neither changes state.

Test Plan:
- Reset, then push instr=0x2A5C0 pc=0x10 with out_ready=1 -> next cycle: out_valid=1, out_instr=0x2A5C0, out_pc=0x10, out_opcode=0x2, out_opA=0x5, out_opB=0xC; the following cycle: out_valid=0 and all outputs 0.
- Stream 0x00001, 0x00002, 0x00003 on consecutive cycles with out_ready=1 -> outputs present them on consecutive cycles; count never exceeds 1; in_ready stays 1.
- out_ready=0, push A=0x11111 then B=0x22222 (DEPTH=2) -> count=2, in_ready=0, out_instr holds 0x11111. Offering C=0x33333 is refused. Then set out_ready=1 -> outputs A, B, C in order with no loss.
- Full queue (count=2), assert flush together with in_valid=1 and out_ready=1 -> next cycle: count=0, out_valid=0, out_* =0, in_ready=1; the flushed-cycle input is absent from the output.
- DEPTH=4 build: perform 10 push/pop pairs with varying stalls so pointers wrap twice -> output order matches input order and count matches the scoreboard every cycle.
- Assert reset while count=3 with out_valid=1 -> next cycle: all outputs zero, count=0, in_ready=1; a subsequent push appears after one cycle.
